// File: rtl/mon_link_pkg.sv
// Shared constants, FSM state types and counter sizing for the monitor serial link.
package mon_link_pkg;

   localparam int FRAME_BITS = 40;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_GAP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Bits needed for a down-counter holding values 0..n.
   function automatic int div_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mon_link_rx.sv
// Deserializer for 40-bit reply frames: one-flop input stage, start check, mid-bit sampling.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for rx_s low
// RX_START | waiting half a bit, then confirming the start bit
// RX_DATA  | sampling 40 data bits, MSB first
// RX_STOP  | sampling the stop bit, pulsing valid or frame error
module mon_link_rx
   import mon_link_pkg::*;
#(
   parameter int BIT_DIV = 1
) (
   input  logic                  mon_clk,
   input  logic                  rst_n,
   input  logic                  from_mon,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_frame_err,
   output logic                  rx_busy
);

   localparam int DIV_W = div_width(BIT_DIV);
   localparam int CNT_W = div_width(FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BIT_DIV / 2);
   localparam logic [DIV_W-1:0] DIV_FULL  = DIV_W'(BIT_DIV);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);

   rx_state_t             rx_state, rx_next;
   logic                  rx_s;
   logic [DIV_W-1:0]      rx_div;
   logic [CNT_W-1:0]      rx_bit;
   logic [FRAME_BITS-1:0] rx_sh;
   logic                  sample;
   logic                  last_bit;

   // Terminal count at 1 so a load of N gives a sample N cycles later.
   assign sample   = (rx_div <= DIV_W'(1));
   assign last_bit = (rx_bit == '0);
   assign rx_busy  = (rx_state != RX_IDLE);

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_s) rx_next = RX_START;
         RX_START: if (sample) rx_next = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (sample && last_bit) rx_next = RX_STOP;
         RX_STOP:  if (sample) rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge mon_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state     <= RX_IDLE;
         rx_s         <= 1'b1;
         rx_div       <= '0;
         rx_bit       <= '0;
         rx_sh        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         rx_state     <= rx_next;
         rx_s         <= from_mon;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
         case (rx_state)
            RX_IDLE: rx_div <= DIV_HALF;
            RX_START: begin
               if (sample) begin
                  rx_div <= DIV_FULL;
                  rx_bit <= DATA_LAST;
               end else begin
                  rx_div <= rx_div - DIV_W'(1);
               end
            end
            RX_DATA: begin
               if (sample) begin
                  rx_div <= DIV_FULL;
                  rx_sh  <= {rx_sh[FRAME_BITS-2:0], rx_s};
                  rx_bit <= rx_bit - CNT_W'(1);
               end else begin
                  rx_div <= rx_div - DIV_W'(1);
               end
            end
            RX_STOP: begin
               if (sample) begin
                  if (rx_s) begin
                     rx_data  <= rx_sh;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_frame_err <= 1'b1;
                  end
               end else begin
                  rx_div <= rx_div - DIV_W'(1);
               end
            end
            default: rx_div <= DIV_HALF;
         endcase
      end
   end

endmodule

// File: rtl/mon_host_link.sv
// Host end of the monitor link: 40-bit command serializer plus the reply deserializer.
//
// state    | meaning
// TX_IDLE  | tx_ready high, waiting for tx_valid
// TX_START | driving the start bit (0)
// TX_DATA  | shifting out 40 data bits, MSB first
// TX_STOP  | driving the stop bit (1)
// TX_GAP   | holding the line idle for GAP_BITS bits
module mon_host_link
   import mon_link_pkg::*;
#(
   parameter int BIT_DIV  = 1,
   parameter int GAP_BITS = 4
) (
   input  logic                  mon_clk,
   input  logic                  rst_n,
   input  logic [FRAME_BITS-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  to_mon,
   input  logic                  from_mon,
   output logic [FRAME_BITS-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  rx_frame_err,
   output logic                  tx_busy,
   output logic                  rx_busy
);

   localparam int DIV_W = div_width(BIT_DIV);
   localparam int CNT_W = div_width((GAP_BITS > FRAME_BITS) ? GAP_BITS : FRAME_BITS);
   localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(BIT_DIV - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   tx_state_t             tx_state, tx_next;
   logic [DIV_W-1:0]      tx_div;
   logic [CNT_W-1:0]      tx_bit;
   logic [FRAME_BITS-1:0] tx_sh;
   logic                  bit_end;
   logic                  last_bit;
   logic                  tx_line;

   assign bit_end  = (tx_div == '0);
   assign last_bit = (tx_bit == '0);
   assign tx_ready = (tx_state == TX_IDLE) && rst_n;
   assign tx_busy  = (tx_state != TX_IDLE);

   always_comb begin
      tx_next = tx_state;
      tx_line = 1'b1;
      case (tx_state)
         TX_IDLE:  if (tx_valid && tx_ready) tx_next = TX_START;
         TX_START: begin
            tx_line = 1'b0;
            if (bit_end) tx_next = TX_DATA;
         end
         TX_DATA: begin
            tx_line = tx_sh[FRAME_BITS-1];
            if (bit_end && last_bit) tx_next = TX_STOP;
         end
         TX_STOP:  if (bit_end) tx_next = (GAP_BITS == 0) ? TX_IDLE : TX_GAP;
         TX_GAP:   if (bit_end && last_bit) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   // to_mon is the registered line value of the current state, one cycle behind it.
   always_ff @(posedge mon_clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_div   <= '0;
         tx_bit   <= '0;
         tx_sh    <= '0;
         to_mon   <= 1'b1;
      end else begin
         tx_state <= tx_next;
         to_mon   <= tx_line;
         if (tx_state == TX_IDLE) begin
            tx_div <= DIV_LOAD;
            if (tx_valid) tx_sh <= tx_data;
         end else if (bit_end) begin
            tx_div <= DIV_LOAD;
            if (tx_state == TX_DATA) tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
            case (tx_state)
               TX_START: tx_bit <= DATA_LAST;
               TX_STOP:  tx_bit <= GAP_LAST;
               default:  tx_bit <= tx_bit - CNT_W'(1);
            endcase
         end else begin
            tx_div <= tx_div - DIV_W'(1);
         end
      end
   end

   mon_link_rx #(
      .BIT_DIV(BIT_DIV)
   ) u_rx (
      .mon_clk     (mon_clk),
      .rst_n       (rst_n),
      .from_mon    (from_mon),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err),
      .rx_busy     (rx_busy)
   );

endmodule

// File: tb/tb_mon_host_link.sv
// Bench for mon_host_link: TX waveform check at BIT_DIV=1, scoreboarded RX/loopback at BIT_DIV=4.
module tb_mon_host_link;

   logic mon_clk = 1'b0;
   always #5 mon_clk = ~mon_clk;

   logic rst_n;

   // Instance A: BIT_DIV=1, transmit waveform checks
   logic [39:0] tx_data_a;
   logic        tx_valid_a, tx_ready_a, to_mon_a, tx_busy_a;
   logic        from_mon_a;
   logic [39:0] rx_data_a;
   logic        rx_valid_a, rx_frame_err_a, rx_busy_a;

   // Instance B: BIT_DIV=4, loopback / driven line
   logic [39:0] tx_data_b;
   logic        tx_valid_b, tx_ready_b, to_mon_b, tx_busy_b;
   logic        from_mon_b;
   logic [39:0] rx_data_b;
   logic        rx_valid_b, rx_frame_err_b, rx_busy_b;
   logic        lb_en, drv_line;

   assign from_mon_a = 1'b1;
   assign from_mon_b = lb_en ? to_mon_b : drv_line;

   mon_host_link #(.BIT_DIV(1), .GAP_BITS(4)) dut_a (
      .mon_clk(mon_clk), .rst_n(rst_n),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .to_mon(to_mon_a), .from_mon(from_mon_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_frame_err(rx_frame_err_a),
      .tx_busy(tx_busy_a), .rx_busy(rx_busy_a)
   );

   mon_host_link #(.BIT_DIV(4), .GAP_BITS(4)) dut_b (
      .mon_clk(mon_clk), .rst_n(rst_n),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .to_mon(to_mon_b), .from_mon(from_mon_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_frame_err(rx_frame_err_b),
      .tx_busy(tx_busy_b), .rx_busy(rx_busy_b)
   );

   typedef struct packed {
      logic        err;
      logic [39:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [39:0] last_good = '0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge mon_clk);
      #1;
   endtask

   task automatic send_b(input logic [39:0] d, input bit push);
      int t = 0;
      while (!tx_ready_b && t < 2000) begin
         tick();
         t++;
      end
      chk("tx_ready_wait", tx_ready_b, 1);
      tx_data_b  = d;
      tx_valid_b = 1'b1;
      tick();
      if (push) sb.push_back({1'b0, d});
      tx_valid_b = 1'b0;
      tx_data_b  = {$urandom, $urandom};
   endtask

   task automatic drive_frame_b(input logic [39:0] d, input logic stop);
      logic [41:0] f;
      f = {1'b0, d, stop};
      sb.push_back({~stop, d});
      for (int i = 41; i >= 0; i--) begin
         drv_line = f[i];
         tick(4);
      end
      drv_line = 1'b1;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 3000) begin
         tick();
         t++;
      end
      chk("sb_drain", sb.size(), 0);
   endtask

   // Scoreboard monitor for instance B
   always @(negedge mon_clk) begin
      exp_t e;
      if (!rst_n) begin
         last_good = '0;
      end else if (rx_valid_b || rx_frame_err_b) begin
         if (sb.size() == 0) begin
            chk("rx_unexpected", {rx_valid_b, rx_frame_err_b}, 2'b00);
         end else begin
            e = sb.pop_front();
            chk("rx_kind", {rx_valid_b, rx_frame_err_b}, e.err ? 2'b01 : 2'b10);
            if (e.err) begin
               chk("rx_hold", rx_data_b, last_good);
            end else begin
               chk("rx_data", rx_data_b, e.data);
               last_good = e.data;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        q[$];
      logic [39:0] d;
      logic        s;
      int          low;

      // Reset behaviour
      rst_n      = 1'b0;
      tx_valid_a = 1'b1;
      tx_data_a  = {$urandom, $urandom};
      tx_valid_b = 1'b1;
      tx_data_b  = {$urandom, $urandom};
      lb_en      = 1'b1;
      drv_line   = 1'b1;
      tick(3);
      chk("rst_to_mon_a", to_mon_a, 1);
      chk("rst_tx_ready_a", tx_ready_a, 0);
      chk("rst_tx_busy_a", tx_busy_a, 0);
      chk("rst_rx_busy_a", rx_busy_a, 0);
      chk("rst_to_mon_b", to_mon_b, 1);
      chk("rst_tx_ready_b", tx_ready_b, 0);
      chk("rst_rx_pulses_b", {rx_valid_b, rx_frame_err_b, rx_busy_b}, 3'b000);
      chk("rst_rx_data_b", rx_data_b, 0);
      tx_valid_a = 1'b0;
      tx_valid_b = 1'b0;
      @(negedge mon_clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready_a", tx_ready_a, 1);
      chk("post_rst_ready_b", tx_ready_b, 1);
      tick(5);
      chk("post_rst_idle_line", {to_mon_a, to_mon_b, tx_busy_a}, 3'b110);

      // TX waveform at BIT_DIV=1
      d = 40'hA50F001234;
      q.push_back(1'b0);
      for (int i = 39; i >= 0; i--) q.push_back(d[i]);
      for (int i = 0; i < 5; i++) q.push_back(1'b1);
      tx_data_a  = d;
      tx_valid_a = 1'b1;
      tick();
      tx_valid_a = 1'b0;
      tx_data_a  = 40'hFFFFFFFFFF;
      chk("tx_hs_line", to_mon_a, 1);
      low = 0;
      for (int k = 0; k < 46; k++) begin
         if (!tx_ready_a) low++;
         tick();
         chk("tx_bit", to_mon_a, q[k]);
      end
      chk("tx_ready_rise", tx_ready_a, 1);
      chk("tx_low_cycles", low, 46);
      tick(3);
      chk("tx_after_idle", {to_mon_a, tx_busy_a}, 2'b10);

      // Loopback back-to-back at BIT_DIV=4
      send_b(40'hC000000001, 1'b1);
      send_b(40'h0000000000, 1'b1);
      drain();

      // Single-cycle glitch then a good frame
      tick(20);
      lb_en    = 1'b0;
      drv_line = 1'b1;
      tick(8);
      drv_line = 1'b0;
      tick();
      drv_line = 1'b1;
      tick(2);
      chk("glitch_started", rx_busy_b, 1);
      tick(6);
      chk("glitch_idle", rx_busy_b, 0);
      drive_frame_b(40'h123456789A, 1'b1);
      tick(12);
      drain();

      // Bad stop bit
      drive_frame_b(40'hFFFFFFFFFF, 1'b0);
      tick(16);
      drain();
      chk("ferr_rx_idle", rx_busy_b, 0);
      chk("ferr_data_held", rx_data_b, 40'h123456789A);

      // Reset in the middle of a TX frame with RX in progress
      lb_en = 1'b1;
      tick(2);
      send_b(40'h0000000000, 1'b0);
      tick(43);
      chk("midrst_line_low", to_mon_b, 0);
      chk("midrst_rx_busy", rx_busy_b, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_async_line", to_mon_b, 1);
      chk("midrst_state", {tx_busy_b, rx_busy_b, tx_ready_b}, 3'b000);
      repeat (3) @(negedge mon_clk);
      chk("midrst_no_pulse", {rx_valid_b, rx_frame_err_b}, 2'b00);
      rst_n = 1'b1;
      tick();
      chk("midrst_rx_data_clr", rx_data_b, 0);
      send_b(40'h5555555555, 1'b1);
      drain();

      // Random loopback traffic
      for (int r = 0; r < 8; r++) begin
         d = {$urandom, $urandom};
         send_b(d, 1'b1);
         tick($urandom_range(0, 30));
      end
      drain();
      tick(24);

      // Random driven frames, some with bad stop bits
      lb_en    = 1'b0;
      drv_line = 1'b1;
      tick(4);
      for (int r = 0; r < 6; r++) begin
         d = {$urandom, $urandom};
         s = 1'($urandom_range(0, 1));
         drive_frame_b(d, s);
         tick(16);
      end
      drain();
      chk("end_rx_idle", rx_busy_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mon_host_link.md
Name: mon_host_link

Overview:
- Host-side (CPU-board) end of the monitor serial link; the counterpart of the peripheral's packet receiver and sender.
- Serializes 40-bit command packets onto to_mon and deserializes 40-bit reply packets from from_mon.
- Used as a bus-master emulator for bring-up and in loopback benches. Runs entirely in the mon_clk domain.

Parameters:
- BIT_DIV, 1: mon_clk cycles per serial bit, >=1.
- GAP_BITS, 4: idle (1) bits TX holds after each stop bit before the next start bit, >=0.

Ports:
- mon_clk  in  1  link clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  40  packet to send, bit 39 first.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX can accept a packet.
- to_mon  out  1  serial line toward peripheral, idle high.
- from_mon  in  1  serial line from peripheral, idle high.
- rx_data  out  40  last good received packet.
- rx_valid  out  1  one-cycle pulse, rx_data newly updated.
- rx_frame_err  out  1  one-cycle pulse, received frame had bad stop bit.
- tx_busy  out  1  TX not in IDLE.
- rx_busy  out  1  RX not in IDLE.

Behaviour:
- Frame format: start bit 0, then 40 data bits MSB first (bit 39 to bit 0), then stop bit 1. The line is 1 when idle.
- Reset state (async on rst_n low):
  - to_mon=1, tx_ready=0, tx_busy=0, rx_busy=0.
  - rx_valid=0, rx_frame_err=0, rx_data=0.
  - Both FSMs go to IDLE. A frame in progress is aborted with no partial output.
- tx_ready=1 exactly when the TX FSM is in IDLE and rst_n is high.
- TX FSM (IDLE, START, DATA, STOP, GAP):
  - Handshake: tx_valid && tx_ready on an edge captures tx_data into a shift register and moves IDLE to START.
  - to_mon is registered. It goes to 0 on the edge after the handshake edge.
  - Each bit is held exactly BIT_DIV cycles. A bit counter and a divider counter track position.
  - START lasts 1 bit, DATA 40 bits, STOP 1 bit, then GAP for GAP_BITS bits with to_mon=1. If GAP_BITS=0, STOP returns directly to IDLE.
  - tx_ready is low for exactly (42+GAP_BITS)*BIT_DIV cycles per packet.
  - tx_data changes while busy are ignored.
- RX path:
  - from_mon passes through one register stage (rx_s).
  - RX FSM has states IDLE, START, DATA, STOP.
  - IDLE: rx_s=0 moves to START and loads the divider with BIT_DIV/2 (integer division).
  - START: when the divider expires, re-sample rx_s. If 0, go to DATA with the divider = BIT_DIV. If 1, it is a false start: return to IDLE with no pulse.
  - DATA: sample rx_s every BIT_DIV cycles (mid-bit) and shift in MSB first, 40 samples.
  - STOP: sample once more.
    - If 1: rx_data is updated and rx_valid pulses on the same edge.
    - If 0: rx_frame_err pulses and rx_data is held.
    - Either way, return to IDLE.
  - rx_valid and rx_frame_err are never high together. Each is high for one cycle only.
  - RX latency: rx_valid rises on the edge at which the stop bit is sampled.
  - With BIT_DIV=1, START samples on the cycle after detection.
- TX and RX are fully independent and may be active at the same time.
- A line stuck at 0 after a frame error re-triggers START only after returning to IDLE. Each further 0 frame produces its own frame-error pulse.

Decomposition:
- Package mon_link_pkg holds:
  - FRAME_BITS=40.
  - The TX state enum (IDLE, START, DATA, STOP, GAP).
  - The RX state enum (IDLE, START, DATA, STOP).
  - A function giving the divider width from BIT_DIV.
- Sub-module mon_link_rx contains the deserializer: sync stage, RX FSM, rx_* outputs.
- The TX FSM stays in mon_host_link.

Test Plan:
- Reset: hold rst_n=0 with tx_valid=1 -> to_mon=1, tx_ready=0, no pulses. After release, tx_ready=1 on the first edge, and to_mon stays 1 until a handshake.
- TX, BIT_DIV=1, GAP_BITS=4, tx_data=40'hA50F001234:
  - to_mon = 0, then the 40 bits MSB first (1,0,1,0,0,1,0,1,...), then 1 for the stop bit, then four 1s.
  - tx_ready is low for 46 cycles and rises on the 47th edge.
- Loopback, to_mon to from_mon, BIT_DIV=4: send 40'hC000000001 then 40'h0000000000 back-to-back -> two rx_valid pulses with rx_data matching in order, and no rx_frame_err.
- Frame error: drive a frame with payload 40'hFFFFFFFFFF and stop bit 0 -> a single rx_frame_err pulse, rx_valid stays 0, and rx_data keeps its previous value.
- Glitch start, BIT_DIV=4: from_mon low for 1 cycle, then high -> RX returns to IDLE, no rx_valid and no rx_frame_err. A following valid frame 40'h123456789A is received correctly.
- Mid-frame reset: assert rst_n=0 after 10 data bits of TX plus an RX in progress -> to_mon=1 asynchronously, no rx pulses. After release, a fresh packet 40'h5555555555 round-trips correctly in loopback.
